ah_lru_lock_arbiter: RTL and testbench

Locking least-recently-used arbiter that shares one resource among N requesters. A grant is held until the owner signals completion or drops its request. A winner is chosen from a rank table that demotes each grantee to lowest priority. It sits in front of shared ports that need multi-cycle ownership. Single-cycle arbitration between pending requesters follows the LRU rank rule.

---
 rtl/ah_arb_pkg.sv | 18 +
 rtl/ah_lru_lock_arbiter_if.sv | 23 ++
 rtl/ah_lru_lock_arbiter_rank.sv | 56 +++++
 rtl/ah_lru_lock_arbiter.sv | 106 ++++++++++
 tb/tb_ah_lru_lock_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ah_arb_pkg.sv
// rtl/ah_arb_pkg.sv - shared FSM state, rank width and reset rank formula for the LRU lock arbiter
package ah_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int rank_w(input int n);
    return $clog2(n);
  endfunction

  // Requester 0 starts with the top rank so it wins the first arbitration.
  function automatic int reset_rank(input int n, input int i);
    return n - 1 - i;
  endfunction

endpackage

// File: rtl/ah_lru_lock_arbiter_if.sv
// rtl/ah_lru_lock_arbiter_if.sv - request/grant bundle between requesters and the lock arbiter
interface ah_lru_lock_arbiter_if #(
  parameter int N     = 7,
  parameter int TMO_W = 8
);
  logic [N-1:0]         req;
  logic [N-1:0]         done;
  logic [TMO_W-1:0]     tmo_cfg;
  logic [N-1:0]         gnt;
  logic                 gnt_vld;
  logic [$clog2(N)-1:0] gnt_id;
  logic                 tmo_evt;

  modport master (
    output req, done, tmo_cfg,
    input  gnt, gnt_vld, gnt_id, tmo_evt
  );

  modport slave (
    input  req, done, tmo_cfg,
    output gnt, gnt_vld, gnt_id, tmo_evt
  );
endinterface

// File: rtl/ah_lru_lock_arbiter_rank.sv
// rtl/ah_lru_lock_arbiter_rank.sv - LRU rank table with highest-rank pick and demote-on-grant update
module ah_lru_rank
  import ah_arb_pkg::*;
#(
  parameter int  N  = 7,
  localparam int RW = rank_w(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req_mask,
  output logic [N-1:0]  win_oh,
  output logic [RW-1:0] win_idx,
  input  logic          upd_en,
  input  logic [RW-1:0] upd_idx
);

  logic [RW-1:0] rank_q [N];
  logic [RW-1:0] rank_d [N];
  logic [RW-1:0] best;
  logic          found;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    best    = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_mask[i] && (!found || rank_q[i] > best)) begin
        found   = 1'b1;
        best    = rank_q[i];
        win_idx = RW'(i);
      end
    end
    if (found) win_oh[win_idx] = 1'b1;
  end

  // Winner drops to rank 0; everyone that was below it moves up one, keeping a permutation.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rank_d[i] = rank_q[i];
      if (upd_en) begin
        if (RW'(i) == upd_idx) rank_d[i] = '0;
        else if (rank_q[i] < rank_q[upd_idx]) rank_d[i] = rank_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) rank_q[i] <= RW'(reset_rank(N, i));
    end else begin
      rank_q <= rank_d;
    end
  end

endmodule

// File: rtl/ah_lru_lock_arbiter.sv
// rtl/ah_lru_lock_arbiter.sv - locking LRU arbiter top; AH_ARB_TIMEOUT_EN adds the ownership timeout
module ah_lru_lock_arbiter
  import ah_arb_pkg::*;
#(
  parameter int  N     = 7,
  parameter int  TMO_W = 8,
  localparam int RW    = rank_w(N)
) (
  input logic                 clk,
  input logic                 rstn,
  ah_lru_lock_arbiter_if.slave bus
);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_vld_q, gnt_vld_d;
  logic [RW-1:0] gnt_id_q, gnt_id_d;
  logic          tmo_evt_q, tmo_evt_d;
  logic [N-1:0]  win_oh;
  logic [RW-1:0] win_idx;
  logic          upd_en;
  logic          tmo_hit;
  logic          owner_done;

  ah_lru_rank #(.N(N)) u_rank (
    .clk      (clk),
    .rstn     (rstn),
    .req_mask (bus.req),
    .win_oh   (win_oh),
    .win_idx  (win_idx),
    .upd_en   (upd_en),
    .upd_idx  (win_idx)
  );

`ifdef AH_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Counter reads 0 in the first owned cycle, so release lands after exactly tmo_cfg cycles.
  always_comb begin
    cnt_d = '0;
    if (state_q == BUSY) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tmo_hit = (bus.tmo_cfg != '0) && (cnt_q >= bus.tmo_cfg - TMO_W'(1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^bus.tmo_cfg;
  assign tmo_hit        = 1'b0;
`endif

  assign owner_done = bus.done[gnt_id_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    tmo_evt_d = 1'b0;
    upd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = BUSY;
          gnt_d    = win_oh;
          gnt_id_d = win_idx;
          upd_en   = 1'b1;
        end
      end
      BUSY: begin
        if (owner_done || !bus.req[gnt_id_q] || tmo_hit) begin
          state_d   = IDLE;
          gnt_d     = '0;
          tmo_evt_d = tmo_hit && !owner_done;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_vld_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= '0;
      tmo_evt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_id_q  <= gnt_id_d;
      tmo_evt_q <= tmo_evt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.tmo_evt = tmo_evt_q;

endmodule

// File: tb/tb_ah_lru_lock_arbiter.sv
// tb/tb_ah_lru_lock_arbiter.sv - directed and random checks of the lock arbiter against an LRU queue model
module tb_ah_lru_lock_arbiter;

  localparam int N     = 7;
  localparam int TMO_W = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  ah_lru_lock_arbiter_if #(.N(N), .TMO_W(TMO_W)) bus ();

  ah_lru_lock_arbiter #(.N(N), .TMO_W(TMO_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: front of the queue is the most deserving requester; a grantee moves to the back.
  int order[$];
  int owner;
  int held;
  bit evt;

  task automatic model_reset();
    order.delete();
    for (int i = 0; i < N; i++) order.push_back(i);
    owner = -1;
    held  = 0;
    evt   = 1'b0;
  endtask

  task automatic model_update();
    bit d;
    bit tmo;
    evt = 1'b0;
    if (owner < 0) begin
      if (|bus.req) begin
        for (int k = 0; k < order.size(); k++) begin
          if (bus.req[order[k]]) begin
            owner = order[k];
            order.delete(k);
            order.push_back(owner);
            break;
          end
        end
        held = 1;
      end
    end else begin
      d   = bus.done[owner];
      tmo = 1'b0;
`ifdef AH_ARB_TIMEOUT_EN
      tmo = (bus.tmo_cfg != 0) && (held >= int'(bus.tmo_cfg));
`endif
      if (d || !bus.req[owner] || tmo) begin
        evt   = tmo && !d;
        owner = -1;
      end else begin
        held++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_gnt;
    exp_gnt = (owner >= 0) ? N'(1 << owner) : '0;
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    chk("gnt_vld", 32'(bus.gnt_vld), 32'(owner >= 0));
    if (owner >= 0) chk("gnt_id", 32'(bus.gnt_id), 32'(owner));
    chk("tmo_evt", 32'(bus.tmo_evt), 32'(evt));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  // Asynchronous reset assertion, checked before any clock edge, released at a falling edge.
  task automatic do_reset(input logic [N-1:0] req_after);
    rstn = 1'b0;
    #2;
    model_reset();
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    check_outputs();
    @(negedge clk);
    rstn     = 1'b1;
    bus.req  = req_after;
    bus.done = '0;
  endtask

  initial begin
    int hi;
    int evts;
    bit broke;
    logic [N-1:0] r;

    bus.req     = '0;
    bus.done    = '0;
    bus.tmo_cfg = '0;
    model_reset();

    // Reset with everyone requesting: requester 0 first.
    do_reset(7'h7F);
    step();
    chk("first_gnt", 32'(bus.gnt), 32'h01);

    // Owner pulses done on its first cycle: round-robin-like LRU order.
    for (int k = 0; k < 8; k++) begin
      chk("order", 32'(bus.gnt_id), 32'(k % N));
      bus.done = N'(1 << (k % N));
      step();
      chk("idle_gap", 32'(bus.gnt), 32'h0);
      bus.done = '0;
      if (k < 7) step();
    end

    // Lone owner keeps the lock while other requests and foreign done pulses arrive.
    do_reset(7'h08);
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 3) bus.req[5] = 1'b1;
      bus.done = (c == 5) ? 7'h20 : 7'h00;
      chk("hold3", 32'(bus.gnt), 32'h08);
    end
    bus.done = 7'h08;
    bus.req  = 7'h20;
    step();
    chk("rel3", 32'(bus.gnt), 32'h0);
    bus.done = '0;
    step();
    chk("next5", 32'(bus.gnt), 32'h20);

    // Owner drops its request without done.
    do_reset(7'h04);
    step();
    bus.req = '0;
    step();
    chk("drop2_gnt", 32'(bus.gnt), 32'h0);
    chk("drop2_evt", 32'(bus.tmo_evt), 32'h0);

    // Timeout of 4 cycles with no done.
    do_reset(7'h02);
    bus.tmo_cfg = 8'd4;
    hi = 0; evts = 0; broke = 1'b0;
    for (int c = 0; c < 12 && !broke; c++) begin
      step();
      evts += int'(bus.tmo_evt);
      if (bus.gnt[1]) hi++;
      else broke = 1'b1;
    end
`ifdef AH_ARB_TIMEOUT_EN
    chk("tmo_hi_cycles", 32'(hi), 32'd4);
    chk("tmo_evt_count", 32'(evts), 32'd1);
`else
    chk("hold_hi_cycles", 32'(hi), 32'd12);
    chk("hold_evt_count", 32'(evts), 32'd0);
`endif

    // Done on the 4th cycle beats the timeout.
    do_reset(7'h02);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("pre_done", 32'(bus.gnt), 32'h02);
    end
    bus.done = 7'h02;
    step();
    chk("done4_gnt", 32'(bus.gnt), 32'h0);
    chk("done4_evt", 32'(bus.tmo_evt), 32'h0);
    bus.done    = '0;
    bus.tmo_cfg = '0;

    // Reset in the middle of an ownership.
    do_reset(7'h10);
    step();
    step();
    chk("own4", 32'(bus.gnt), 32'h10);
    do_reset(7'h11);
    step();
    chk("after_rst", 32'(bus.gnt), 32'h01);

    // Random traffic against the model.
    do_reset('0);
    r = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) r = r ^ N'(1 << $urandom_range(0, N - 1));
      bus.req  = r;
      bus.done = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 49) == 0) bus.tmo_cfg = TMO_W'($urandom_range(0, 6));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
